// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout,
// stop encodings, per-hazard stall vectors and FSM state encoding.
package pipe_ctrl_pkg;

    // Stall bus: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
    localparam int unsigned STALL_BUS_W = 6;
    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Load-use: freeze PC, IF/ID, ID/EX; EX receives a bubble.
    localparam stall_bus_t STALL_LOAD = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    // Multi-cycle MDU: freeze everything up to and including EX/MEM.
    localparam stall_bus_t STALL_MDU  = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
    // Exception/redirect: freeze everything up to and including MEM/WB.
    localparam stall_bus_t STALL_EXCP = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MDU_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle MDU wait with watchdog,
// and exception flush, plus a saturating stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_W     = STALL_BUS_W,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_for_load,
    input  logic               mdu_start,
    input  logic               mdu_done,
    input  logic               excp_req,
    input  logic [31:0]        excp_target,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               mdu_cancel,
    output logic               mdu_timeout,
    output logic [31:0]        stall_cycles
);

    localparam int unsigned WD_W = $clog2(MDU_TIMEOUT + 1);

    pipe_state_e       state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic              flush_q, flush_d;
    logic [31:0]       flush_pc_q, flush_pc_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       stall_cycles_q, stall_cycles_d;
    logic [STALL_W-1:0] stall_d;
    logic              cancel_d;

    assign wd_inc = wd_q + WD_W'(1);

    // Next-state, same-cycle stall/cancel and registered-output next values.
    // The watchdog fires on the MDU_TIMEOUT-th wait cycle; that cycle behaves
    // like a done cycle (stall released) but also cancels the MDU.
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        stall_d    = '0;
        cancel_d   = 1'b0;
        flush_d    = 1'b0;
        flush_pc_d = '0;
        timeout_d  = timeout_q;
        case (state_q)
            S_RUN: begin
                if (excp_req) begin
                    stall_d    = STALL_W'(STALL_EXCP);
                    state_d    = S_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = excp_target;
                end else if (mdu_start) begin
                    stall_d = STALL_W'(STALL_MDU);
                    state_d = S_MDU_WAIT;
                    wd_d    = '0;
                end else if (stall_for_load) begin
                    stall_d = STALL_W'(STALL_LOAD);
                end
            end
            S_MDU_WAIT: begin
                if (excp_req) begin
                    cancel_d   = 1'b1;
                    stall_d    = STALL_W'(STALL_EXCP);
                    state_d    = S_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = excp_target;
                end else if (mdu_done) begin
                    state_d = S_RUN;
                end else if (wd_inc == WD_W'(MDU_TIMEOUT)) begin
                    cancel_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    stall_d = STALL_W'(STALL_MDU);
                    wd_d    = wd_inc;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held so that an
    // asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        stall      = rst ? stall_d : '0;
        mdu_cancel = rst ? cancel_d : 1'b0;
    end

    // Saturating count of cycles with any stage stopped.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall != '0) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // FSM state, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_RUN;
            wd_q           <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;
    assign mdu_timeout  = timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_for_load = 1'b0;
    logic        mdu_start = 1'b0;
    logic        mdu_done = 1'b0;
    logic        excp_req = 1'b0;
    logic [31:0] excp_target = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mdu_cancel;
    logic        mdu_timeout;
    logic [31:0] stall_cycles;

    int compared = 0;
    int mismatched = 0;

    // Model: "MDU busy" flag with elapsed wait cycles, pending flush with its
    // target, sticky timeout flag and a stalled-cycle tally.
    bit          m_busy;
    int          m_waited;
    bit          m_flush_now;
    logic [31:0] m_flush_pc;
    bit          m_timed_out;
    logic [31:0] m_cycles;

    pipe_ctrl #(.STALL_W(6), .MDU_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .stall_for_load(stall_for_load), .mdu_start(mdu_start),
        .mdu_done(mdu_done), .excp_req(excp_req), .excp_target(excp_target),
        .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .mdu_cancel(mdu_cancel), .mdu_timeout(mdu_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_flush_now = 0; m_flush_pc = '0;
        m_timed_out = 0; m_cycles = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"}, {26'd0, stall}, 32'd0);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
        chk({tag, ".flush_pc"}, flush_pc, 32'd0);
        chk({tag, ".cancel"}, {31'd0, mdu_cancel}, 32'd0);
        chk({tag, ".timeout"}, {31'd0, mdu_timeout}, 32'd0);
        chk({tag, ".cycles"}, stall_cycles, 32'd0);
    endtask

    // One clock cycle: drive inputs after the falling edge, check against the
    // model, then advance the model to what the next rising edge produces.
    task automatic step(input string tag, input bit ld, input bit st, input bit dn,
                        input bit ex, input logic [31:0] tgt);
        logic [5:0] e_stall;
        bit e_cancel;
        bit n_flush;
        @(negedge clk);
        stall_for_load = ld; mdu_start = st; mdu_done = dn;
        excp_req = ex; excp_target = tgt;
        #1;
        e_stall = 6'd0; e_cancel = 0; n_flush = 0;
        if (m_flush_now) begin
            // flush cycle: nothing stalls, requests are ignored
        end else if (m_busy) begin
            if (ex) begin
                e_stall = 6'b011111; e_cancel = 1; n_flush = 1; m_busy = 0;
            end else if (dn) begin
                m_busy = 0;
            end else if (m_waited + 1 == 64) begin
                e_cancel = 1; m_busy = 0;
            end else begin
                e_stall = 6'b001111; m_waited++;
            end
        end else begin
            if (ex) begin
                e_stall = 6'b011111; n_flush = 1;
            end else if (st) begin
                e_stall = 6'b001111; m_busy = 1; m_waited = 0;
            end else if (ld) begin
                e_stall = 6'b000111;
            end
        end
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, m_flush_now});
        chk({tag, ".flush_pc"}, flush_pc, m_flush_now ? m_flush_pc : 32'd0);
        chk({tag, ".cancel"}, {31'd0, mdu_cancel}, {31'd0, e_cancel});
        chk({tag, ".timeout"}, {31'd0, mdu_timeout}, {31'd0, m_timed_out});
        chk({tag, ".cycles"}, stall_cycles, m_cycles);
        if (e_cancel && !ex) m_timed_out = 1;
        if (e_stall != 6'd0 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        m_flush_now = n_flush;
        m_flush_pc  = n_flush ? tgt : 32'd0;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset state with a hazard input active: outputs must stay low.
        stall_for_load = 1'b1;
        #1;
        check_all_zero("reset");
        stall_for_load = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Load-use, single cycle.
        step("load", 1, 0, 0, 0, 32'd0);
        idle("load_after");
        chk("load_cycles", stall_cycles, 32'd1);

        // MDU with done 5 cycles after start.
        step("mdu_start", 0, 1, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++) step("mdu_wait", 0, 0, 0, 0, 32'd0);
        step("mdu_done", 0, 0, 1, 0, 32'd0);
        idle("mdu_after");

        // Exception held until the flush is seen.
        step("excp", 0, 0, 0, 1, 32'hBFC0_0380);
        step("excp_flush", 0, 1, 0, 1, 32'hBFC0_0380);
        idle("excp_after");

        // Exception racing mdu_done inside MDU_WAIT; mdu_start ignored there.
        step("mx_start", 0, 1, 0, 0, 32'd0);
        step("mx_wait", 0, 1, 0, 0, 32'd0);
        step("mx_race", 0, 0, 1, 1, 32'h8000_0180);
        step("mx_flush", 0, 0, 1, 0, 32'd0);
        idle("mx_after");

        // Watchdog: no done at all.
        step("wd_start", 0, 1, 0, 0, 32'd0);
        for (int i = 0; i < 64; i++) idle("wd_wait");
        idle("wd_after");
        chk("wd_sticky", {31'd0, mdu_timeout}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom);
        end

        // Asynchronous reset in the middle of MDU_WAIT, away from any clock edge.
        step("ar_start", 0, 1, 0, 0, 32'd0);
        step("ar_wait", 1, 0, 0, 0, 32'd0);
        @(negedge clk);
        stall_for_load = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        stall_for_load = 1'b0;
        rst = 1'b1;
        step("post_rst_load", 1, 0, 0, 0, 32'd0);
        step("post_rst_mdu", 0, 1, 0, 0, 32'd0);
        step("post_rst_done", 0, 0, 1, 0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
